// File: rtl/estu_simd_pkg.sv
// Shared state encoding and the saturating-add helper for the 2-lane SIMD accumulator.
package estu_simd_pkg;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  // Working width of sat_add; accumulators must be narrower than this.
  localparam int MAX_W = 48;

  typedef logic signed [MAX_W-1:0] wide_t;

  typedef struct packed {
    logic  clip;
    wide_t result;
  } sat_res_t;

  // Adds two sign-extended values one bit wider than the operands, then clips
  // to the signed range of an acc_w-bit accumulator.
  function automatic sat_res_t sat_add(input wide_t acc, input wide_t sum, input int acc_w);
    logic signed [MAX_W:0] total;
    logic signed [MAX_W:0] hi;
    logic signed [MAX_W:0] lo;
    logic        [MAX_W:0] one;
    sat_res_t              res;
    one   = {{MAX_W{1'b0}}, 1'b1};
    total = $signed({acc[MAX_W-1], acc}) + $signed({sum[MAX_W-1], sum});
    hi    = $signed((one << (acc_w - 1)) - one);
    lo    = -$signed(one << (acc_w - 1));
    res.clip = 1'b1;
    if (total > hi) begin
      res.result = hi[MAX_W-1:0];
    end else if (total < lo) begin
      res.result = lo[MAX_W-1:0];
    end else begin
      res.clip   = 1'b0;
      res.result = total[MAX_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_accum_lane.sv
// One lane: saturating signed accumulator with a sticky clip flag.
module sat_accum_lane
  import estu_simd_pkg::*;
#(
  parameter int W     = 15,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    add_en_i,
  input  logic                    frame_clr_i,
  input  logic signed [W:0]       sum_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic                    sat_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    sat_q, sat_d;
  sat_res_t                add_res;
  logic                    unused_hi;

  always_comb add_res = sat_add(MAX_W'(acc_q), MAX_W'(sum_i), ACC_W);

  // Bits above ACC_W are always the sign copy after clipping.
  assign unused_hi = ^add_res.result[MAX_W-1:ACC_W];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (frame_clr_i) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (add_en_i) begin
      acc_d = add_res.result[ACC_W-1:0];
      sat_d = sat_q | add_res.clip;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign acc_o = acc_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/adder_simd_accum.sv
// Consumes 2-lane adder sums, accumulates LEN per frame, and freezes the adder while a frame waits.
module adder_simd_accum
  import estu_simd_pkg::*;
#(
  parameter int W     = 15,
  parameter int ACC_W = 24,
  parameter int LEN   = 16,
  parameter int LAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    issue,
  output logic                    adder_en,
  input  logic signed [W:0]       sum_0,
  input  logic signed [W:0]       sum_1,
  output logic                    acc_valid,
  input  logic                    acc_ready,
  output logic signed [ACC_W-1:0] acc_0,
  output logic signed [ACC_W-1:0] acc_1,
  output logic                    sat_0,
  output logic                    sat_1
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [LAT-1:0]     vld_sr_q, vld_sr_d;
  logic               sum_valid, last_sum, handshake, frame_clr;

  assign adder_en  = (state_q == ACCUM);
  assign acc_valid = (state_q == HOLD);
  assign sum_valid = adder_en & vld_sr_q[LAT-1];
  assign last_sum  = sum_valid && (count_q == CNT_W'(LEN - 1));
  assign handshake = acc_valid & acc_ready;
  assign frame_clr = clr | handshake;

  // Count wraps to zero on the last sum, so it already reads zero throughout HOLD.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    vld_sr_d = vld_sr_q;
    if (adder_en) begin
      vld_sr_d    = vld_sr_q << 1;
      vld_sr_d[0] = issue;
    end
    case (state_q)
      ACCUM: begin
        if (sum_valid) begin
          count_d = last_sum ? '0 : count_q + CNT_W'(1);
          if (last_sum) state_d = HOLD;
        end
      end
      HOLD: begin
        if (acc_ready) state_d = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      count_q  <= '0;
      vld_sr_q <= '0;
    end else if (clr) begin
      state_q  <= ACCUM;
      count_q  <= '0;
      vld_sr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      vld_sr_q <= vld_sr_d;
    end
  end

  sat_accum_lane #(.W(W), .ACC_W(ACC_W)) u_lane0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .add_en_i    (sum_valid),
    .frame_clr_i (frame_clr),
    .sum_i       (sum_0),
    .acc_o       (acc_0),
    .sat_o       (sat_0)
  );

  sat_accum_lane #(.W(W), .ACC_W(ACC_W)) u_lane1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .add_en_i    (sum_valid),
    .frame_clr_i (frame_clr),
    .sum_i       (sum_1),
    .acc_o       (acc_1),
    .sat_o       (sat_1)
  );

endmodule

// File: tb/tb_adder_simd_accum.sv
// Directed bench: two accumulator instances, each fed by a small 2-stage adder model.
module tb_adder_simd_accum;

  localparam int W = 15;

  logic clk, rst_n, clr, issue, acc_ready;
  logic signed [W-1:0] a_0, b_0, a_1, b_1;

  // Instance A: ACC_W=16, LEN=4.  Instance B: ACC_W=24, LEN=2.
  logic                en_a, valid_a, sat0_a, sat1_a;
  logic signed [W:0]   s0_a, s1_a;
  logic signed [15:0]  acc0_a, acc1_a;
  logic                en_b, valid_b, sat0_b, sat1_b;
  logic signed [W:0]   s0_b, s1_b;
  logic signed [23:0]  acc0_b, acc1_b;

  logic signed [W-1:0] ra [4];
  logic signed [W-1:0] rb [4];

  int checks   = 0;
  int failures = 0;

  adder_simd_accum #(.W(W), .ACC_W(16), .LEN(4), .LAT(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .issue(issue), .adder_en(en_a),
    .sum_0(s0_a), .sum_1(s1_a), .acc_valid(valid_a), .acc_ready(acc_ready),
    .acc_0(acc0_a), .acc_1(acc1_a), .sat_0(sat0_a), .sat_1(sat1_a)
  );

  adder_simd_accum #(.W(W), .ACC_W(24), .LEN(2), .LAT(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .issue(issue), .adder_en(en_b),
    .sum_0(s0_b), .sum_1(s1_b), .acc_valid(valid_b), .acc_ready(acc_ready),
    .acc_0(acc0_b), .acc_1(acc1_b), .sat_0(sat0_b), .sat_1(sat1_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder models: operand register stage, then sum register stage, both gated by en.
  always @(posedge clk) begin
    if (!rst_n || clr) begin
      ra <= '{4{'0}}; s0_a <= '0; s1_a <= '0;
    end else if (en_a) begin
      ra <= '{a_0, b_0, a_1, b_1};
      s0_a <= ra[0] + ra[1];
      s1_a <= ra[2] + ra[3];
    end
  end

  always @(posedge clk) begin
    if (!rst_n || clr) begin
      rb <= '{4{'0}}; s0_b <= '0; s1_b <= '0;
    end else if (en_b) begin
      rb <= '{a_0, b_0, a_1, b_1};
      s0_b <= rb[0] + rb[1];
      s1_b <= rb[2] + rb[3];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Presents operands whose pairwise sums are s0 (lane 0) and s1 (lane 1).
  task automatic drive(input int s0, input int s1);
    a_0   = W'(s0 - 100);
    b_0   = W'(100);
    a_1   = W'(s1 + 50);
    b_1   = W'(-50);
    issue = 1'b1;
  endtask

  // Called at a negedge; holds the pair until the target's adder_en accepts it.
  task automatic send(input int tgt, input int s0, input int s1);
    logic took;
    int   n;
    drive(s0, s1);
    took = 1'b0;
    n    = 0;
    while (!took && n < 50) begin
      took = (tgt == 0) ? en_a : en_b;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("send_accept", took, 1);
  endtask

  task automatic expect_frame(input string tag, input int e0, input int e1,
                              input logic es0, input logic es1);
    int n;
    n = 0;
    while (!valid_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, valid_a, 1);
    check({tag, "_acc0"},  acc0_a, e0);
    check({tag, "_acc1"},  acc1_a, e1);
    check({tag, "_sat0"},  sat0_a, es0);
    check({tag, "_sat1"},  sat1_a, es1);
    @(negedge clk);
  endtask

  int            en_low;
  int            f0 [$];
  int            f1 [$];

  initial begin
    rst_n = 1'b0; clr = 1'b0; issue = 1'b0; acc_ready = 1'b1;
    a_0 = '0; b_0 = '0; a_1 = '0; b_1 = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", valid_a, 0);
    check("rst_en",    en_a,    1);
    check("rst_acc0",  acc0_a,  0);
    check("rst_sat0",  sat0_a,  0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame and its latency: valid appears LAT+1 cycles after the 4th issue.
    send(0, 10, -3); send(0, 20, -3); send(0, 30, -3); send(0, 40, -3);
    issue = 1'b0;
    check("t2_lat1", valid_a, 0);
    @(negedge clk);
    check("t2_lat2", valid_a, 0);
    @(negedge clk);
    check("t2_valid", valid_a, 1);
    check("t2_acc0",  acc0_a, 100);
    check("t2_acc1",  acc1_a, -12);
    check("t2_sat0",  sat0_a, 0);
    check("t2_sat1",  sat1_a, 0);
    check("t2_en",    en_a,   0);
    @(negedge clk);
    check("t2_after_valid", valid_a, 0);
    check("t2_after_en",    en_a,    1);
    check("t2_after_acc0",  acc0_a,  0);

    // Async reset mid-frame with three sums accumulated.
    repeat (3) send(0, 1, 2);
    issue = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_partial0", acc0_a, 3);
    check("t1_partial1", acc1_a, 6);
    rst_n = 1'b0;
    #1;
    check("t1_async_valid", valid_a, 0);
    check("t1_async_acc0",  acc0_a,  0);
    check("t1_async_acc1",  acc1_a,  0);
    check("t1_async_en",    en_a,    1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (3) send(0, 5, 7);
    issue = 1'b0;
    repeat (6) @(negedge clk);
    check("t1_not_early", valid_a, 0);
    send(0, 5, 7);
    issue = 1'b0;
    expect_frame("t1_frame", 20, 28, 0, 0);

    // Saturation in both directions, then flags clear in the next frame.
    repeat (4) send(0, 16000, -16000);
    issue = 1'b0;
    expect_frame("t3_sat", 32767, -32768, 1, 1);
    repeat (4) send(0, 1, 2);
    issue = 1'b0;
    expect_frame("t3_next", 4, 8, 0, 0);

    // Backpressure: frame waits in HOLD while the next pair is held on the inputs.
    acc_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(0, 100 * i, -i);
    drive(700, -7);
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_en",    en_a,    0);
      check("t4_hold_valid", valid_a, 1);
      check("t4_hold_acc0",  acc0_a,  1000);
      check("t4_hold_acc1",  acc1_a,  -10);
      @(negedge clk);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    check("t4_release_valid", valid_a, 0);
    check("t4_release_en",    en_a,    1);
    check("t4_release_acc0",  acc0_a,  0);
    send(0, 700, -7);
    send(0, 800, -8);
    issue = 1'b0;
    expect_frame("t4_next", 2600, -26, 0, 0);

    // Sync clear with one sum accumulated and two sums in flight.
    send(0, 1000, 1);
    issue = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_partial0", acc0_a, 1000);
    send(0, 2000, 2);
    send(0, 3000, 3);
    issue = 1'b0;
    clr   = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("t6_clr_valid", valid_a, 0);
    check("t6_clr_acc0",  acc0_a,  0);
    check("t6_clr_acc1",  acc1_a,  0);
    check("t6_clr_en",    en_a,    1);
    repeat (3) send(0, 7, 9);
    issue = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_not_early", valid_a, 0);
    send(0, 7, 9);
    issue = 1'b0;
    expect_frame("t6_frame", 28, 36, 0, 0);

    // Back-to-back LEN=2 frames on instance B: one bubble per frame, no carry-over.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    en_low = 0;
    @(negedge clk);
    fork
      begin
        for (int i = 1; i <= 6; i++) send(1, i, 10 * i);
        issue = 1'b0;
      end
      begin
        repeat (30) begin
          @(negedge clk);
          if (!en_b) en_low++;
          if (valid_b) begin
            f0.push_back(int'(acc0_b));
            f1.push_back(int'(acc1_b));
          end
        end
      end
    join
    check("t5_bubbles", en_low,    3);
    check("t5_frames",  f0.size(), 3);
    if (f0.size() == 3) begin
      check("t5_f0_acc0", f0[0], 3);
      check("t5_f0_acc1", f1[0], 30);
      check("t5_f1_acc0", f0[1], 7);
      check("t5_f1_acc1", f1[1], 70);
      check("t5_f2_acc0", f0[2], 11);
      check("t5_f2_acc1", f1[2], 110);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
